wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/k11_pkg.sv | 11 +
 rtl/rr_pick.sv | 30 +++
 rtl/wb_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/k11_pkg.sv
// k11_pkg: shared widths, writeback requester indices and the cyclic-distance helper
package k11_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int REQ_LSU = 0;
  localparam int REQ_MDU = 1;
  localparam int REQ_ALU = 2;
  function automatic int cyc_dist(input int k, input int p, input int n);
    return (k - p + n) % n;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: cyclic priority pick of the first valid requester at or after ptr_i
//   valid_i : request vector
//   ptr_i   : highest-priority index (0 gives fixed lowest-index priority)
//   grant_o : one-hot grant, idx_o : granted index, any_o : some request valid
module rr_pick
  import k11_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [2:0]      idx_o,
  output logic            any_o
);
  int best;
  always_comb begin
    best = NREQ;
    idx_o = '0;
    any_o = 1'b0;
    grant_o = '0;
    for (int k = 0; k < NREQ; k++)
      if (valid_i[k] && cyc_dist(k, int'(ptr_i), NREQ) < best) begin
        best = cyc_dist(k, int'(ptr_i), NREQ);
        idx_o = k[2:0];
        any_o = 1'b1;
      end
    for (int k = 0; k < NREQ; k++) grant_o[k] = any_o && idx_o == k[2:0];
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates NREQ writeback requesters onto one register-file write port
//   req_valid_i/req_rd_i/req_data_i : per-requester writeback (slice i = requester i)
//   req_ready_o : one-hot combinational grant (accept = valid & ready)
//   wb_o/wb_r_o/result_o/wb_src_o : registered write port, one cycle after acceptance
//   WB_ARB_RR_EN defined: round-robin; undefined: fixed priority, lowest index wins
module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = k11_pkg::XLEN,
  parameter int REG_W = k11_pkg::REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*REG_W-1:0] req_rd_i,
  input  logic [NREQ*XLEN-1:0]  req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  wb_o,
  output logic [REG_W-1:0]      wb_r_o,
  output logic [XLEN-1:0]       result_o,
  output logic [2:0]            wb_src_o
);
  logic [NREQ-1:0] grant;
  logic [2:0] idx, ptr;
  logic any, acc;
  logic [REG_W-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  logic wb_q;
  logic [REG_W-1:0] rd_q;
  logic [XLEN-1:0] data_q;
  logic [2:0] src_q;
`ifdef WB_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
  assign ptr_d = acc ? (idx == 3'(NREQ - 1) ? 3'd0 : idx + 3'd1) : ptr_q;
  always_ff @(posedge clk)
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
`else
  assign ptr = 3'd0;
`endif
  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i(req_valid_i),
    .ptr_i  (ptr),
    .grant_o(grant),
    .idx_o  (idx),
    .any_o  (any)
  );
  // Nothing is granted while held in reset, so pending requests survive it.
  assign req_ready_o = rst ? grant : '0;
  assign acc = rst && any;
  always_comb begin
    sel_rd = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++)
      if (idx == k[2:0]) begin
        sel_rd = req_rd_i[k*REG_W +: REG_W];
        sel_data = req_data_i[k*XLEN +: XLEN];
      end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      wb_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      src_q <= '0;
    end else begin
      wb_q <= acc;
      if (acc) begin
        rd_q <= sel_rd;
        data_q <= sel_data;
        src_q <= idx;
      end
    end
  assign wb_o = wb_q;
  assign wb_r_o = rd_q;
  assign result_o = data_q;
  assign wb_src_o = src_q;
endmodule
